// File: rtl/axi_output_arbiter.sv
// Round-robin burst arbiter sharing one AXI output buffer between NumPorts
// stream producers through a single registered output stage.
module axi_output_arbiter #(
    parameter int DataWidth = 16,
    parameter int NumPorts  = 4,
    parameter int MaxBurst  = 16
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NumPorts-1:0]           reqValid,
    input  logic [NumPorts*DataWidth-1:0] reqData,
    input  logic [NumPorts-1:0]           reqLast,
    output logic [NumPorts-1:0]           reqStop,
    output logic                          dataOutValid,
    output logic [DataWidth-1:0]          dataOut,
    output logic                          dataOutLast,
    input  logic                          dataOutStop,
    output logic [$clog2(NumPorts)-1:0]   grantId,
    output logic                          busy
);

    localparam int IdW  = $clog2(NumPorts);
    localparam int CntW = $clog2(MaxBurst) + 1;

    // state | meaning
    // IDLE  | no owner; next requester chosen scanning upward from rrPtr
    // GRANT | grantId owns the output until its last word or the burst limit
    typedef enum logic {IDLE, GRANT} stateT;

    stateT                state, stateNext;
    logic [IdW-1:0]       rrPtr, rrPtrNext, pick;
    logic                 pickValid;
    int                   scanIdx;
    logic [CntW-1:0]      burstCnt;
    logic                 grantValid, grantLast, atLimit;
    logic [DataWidth-1:0] grantData;
    logic                 outFullStalled, accept, burstEnd;

    // Scan from the highest offset down so the lowest offset from rrPtr wins.
    always_comb begin
        pick      = rrPtr;
        pickValid = 1'b0;
        scanIdx   = 0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            scanIdx = (int'(rrPtr) + i) % NumPorts;
            if (reqValid[scanIdx]) begin
                pick      = IdW'(scanIdx);
                pickValid = 1'b1;
            end
        end
    end

    always_comb begin
        grantValid     = reqValid[grantId];
        grantLast      = reqLast[grantId];
        grantData      = reqData[int'(grantId) * DataWidth +: DataWidth];
        outFullStalled = dataOutValid & dataOutStop;
        atLimit        = (burstCnt == CntW'(MaxBurst - 1));
        accept         = (state == GRANT) & grantValid & ~outFullStalled;
        burstEnd       = accept & (grantLast | atLimit);
        rrPtrNext      = (grantId == IdW'(NumPorts - 1)) ? '0 : grantId + 1'b1;
        busy           = (state == GRANT);
    end

    // The stall path to the granted port is combinational so a draining
    // register can be refilled in the same cycle.
    always_comb begin
        reqStop = '1;
        if (state == GRANT) begin
            reqStop[grantId] = outFullStalled;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (pickValid) stateNext = GRANT;
            GRANT:   if (burstEnd)  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= IDLE;
            rrPtr        <= '0;
            grantId      <= '0;
            burstCnt     <= '0;
            dataOutValid <= 1'b0;
            dataOut      <= '0;
            dataOutLast  <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE && pickValid) begin
                grantId  <= pick;
                burstCnt <= '0;
            end
            if (accept) begin
                burstCnt     <= burstEnd ? '0 : burstCnt + CntW'(1);
                dataOut      <= grantData;
                dataOutLast  <= grantLast | atLimit;
                dataOutValid <= 1'b1;
            end else if (dataOutValid && !dataOutStop) begin
                dataOutValid <= 1'b0;
            end
            if (burstEnd) begin
                rrPtr <= rrPtrNext;
            end
        end
    end

endmodule

// File: tb/tb_axi_output_arbiter.sv
// Directed bench for axi_output_arbiter: a default instance (MaxBurst=16) and
// a MaxBurst=1 instance, checked with immediate assertions.
module tb_axi_output_arbiter;

    localparam int DW = 16;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic srst;

    logic [NP-1:0]    reqValid, reqLast, reqStop;
    logic [NP*DW-1:0] reqData;
    logic             dataOutValid, dataOutLast, dataOutStop, busy;
    logic [DW-1:0]    dataOut;
    logic [1:0]       grantId;

    logic [NP-1:0]    reqValid1, reqLast1, reqStop1;
    logic [NP*DW-1:0] reqData1;
    logic             dataOutValid1, dataOutLast1, dataOutStop1, busy1;
    logic [DW-1:0]    dataOut1;
    logic [1:0]       grantId1;

    int checks = 0;
    int errors = 0;
    int g;

    always #5 clk = ~clk;

    axi_output_arbiter #(.DataWidth(DW), .NumPorts(NP), .MaxBurst(16)) u_dut (
        .clk(clk), .srst(srst),
        .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast), .reqStop(reqStop),
        .dataOutValid(dataOutValid), .dataOut(dataOut), .dataOutLast(dataOutLast),
        .dataOutStop(dataOutStop), .grantId(grantId), .busy(busy)
    );

    axi_output_arbiter #(.DataWidth(DW), .NumPorts(NP), .MaxBurst(1)) u_dut1 (
        .clk(clk), .srst(srst),
        .reqValid(reqValid1), .reqData(reqData1), .reqLast(reqLast1), .reqStop(reqStop1),
        .dataOutValid(dataOutValid1), .dataOut(dataOut1), .dataOutLast(dataOutLast1),
        .dataOutStop(dataOutStop1), .grantId(grantId1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic [15:0] expData, input logic expLast);
        check({tag, " valid"}, 32'(dataOutValid), 32'(1));
        check({tag, " data"}, 32'(dataOut), 32'(expData));
        check({tag, " last"}, 32'(dataOutLast), 32'(expLast));
    endtask

    task automatic checkReset(input string tag);
        check({tag, " busy"}, 32'(busy), 32'(0));
        check({tag, " valid"}, 32'(dataOutValid), 32'(0));
        check({tag, " data"}, 32'(dataOut), 32'(0));
        check({tag, " last"}, 32'(dataOutLast), 32'(0));
        check({tag, " grantId"}, 32'(grantId), 32'(0));
        check({tag, " reqStop"}, 32'(reqStop), 32'(4'hF));
    endtask

    task automatic setPort(input int p, input logic [15:0] d, input logic v, input logic l);
        reqData[p*DW +: DW] = d;
        reqValid[p]         = v;
        reqLast[p]          = l;
    endtask

    function automatic logic [15:0] wd(input int i, input int w);
        return 16'((i + 1) * 4096 + w);
    endfunction

    function automatic logic [3:0] stopMask(input int p);
        return ~(4'b0001 << p);
    endfunction

    initial begin
        srst = 1'b1;
        reqValid = '0; reqLast = '0; reqData = '0; dataOutStop = 1'b0;
        reqValid1 = '0; reqLast1 = '0; reqData1 = '0; dataOutStop1 = 1'b0;
        g = 0;
        tick(); tick();
        checkReset("reset");
        srst = 1'b0;

        // Single port 0, three-word burst
        setPort(0, 16'h0011, 1'b1, 1'b0);
        tick();
        check("t1 busy", 32'(busy), 32'(1));
        check("t1 grant", 32'(grantId), 32'(0));
        check("t1 reqStop", 32'(reqStop), 32'(4'b1110));
        tick(); checkOut("t1 w0", 16'h0011, 1'b0); setPort(0, 16'h0022, 1'b1, 1'b0);
        tick(); checkOut("t1 w1", 16'h0022, 1'b0); setPort(0, 16'h0033, 1'b1, 1'b1);
        tick(); checkOut("t1 w2", 16'h0033, 1'b1);
        check("t1 busy end", 32'(busy), 32'(0));
        // rrPtr is now 1, so port 1 beats port 0
        setPort(0, 16'h00A0, 1'b1, 1'b1);
        setPort(1, 16'h01A0, 1'b1, 1'b1);
        tick();
        check("t1 drained", 32'(dataOutValid), 32'(0));
        check("t1 rr grant", 32'(grantId), 32'(1));
        tick(); checkOut("t1 rr word", 16'h01A0, 1'b1);
        reqValid = '0; reqLast = '0;
        tick();
        srst = 1'b1; tick(); srst = 1'b0;

        // All four ports valid, two-word bursts
        for (int i = 0; i < NP; i++) setPort(i, wd(i, 0), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            g = k % NP;
            tick();
            check("t2 grant", 32'(grantId), 32'(g));
            check("t2 reqStop", 32'(reqStop), 32'(stopMask(g)));
            tick(); checkOut("t2 w0", wd(g, 0), 1'b0); setPort(g, wd(g, 1), 1'b1, 1'b1);
            tick(); checkOut("t2 w1", wd(g, 1), 1'b1);
            check("t2 bubble", 32'(busy), 32'(0));
            setPort(g, wd(g, 0), 1'b1, 1'b0);
        end
        reqValid = '0; reqLast = '0;
        tick(); tick();
        srst = 1'b1; tick(); srst = 1'b0;

        // Port 2 streams 20 words without last; MaxBurst cuts at 16
        setPort(2, 16'h2000, 1'b1, 1'b0);
        tick();
        check("t3 grant", 32'(grantId), 32'(2));
        for (int w = 0; w < 16; w++) begin
            tick(); checkOut("t3 word", 16'(16'h2000 + w), w == 15);
            setPort(2, 16'(16'h2000 + w + 1), 1'b1, 1'b0);
        end
        check("t3 limit release", 32'(busy), 32'(0));
        setPort(3, 16'h3333, 1'b1, 1'b1);
        tick(); check("t3 next grant", 32'(grantId), 32'(3));
        tick(); checkOut("t3 p3 word", 16'h3333, 1'b1); setPort(3, 16'h0000, 1'b0, 1'b0);
        tick(); check("t3 regrant", 32'(grantId), 32'(2));
        for (int w = 16; w < 20; w++) begin
            tick(); checkOut("t3 tail", 16'(16'h2000 + w), w == 19);
            if (w < 19) setPort(2, 16'(16'h2000 + w + 1), 1'b1, (w + 1) == 19);
            else setPort(2, 16'h0000, 1'b0, 1'b0);
        end
        check("t3 done", 32'(busy), 32'(0));

        // Downstream stall for five cycles mid-burst
        setPort(1, 16'h4000, 1'b1, 1'b0);
        tick(); check("t4 grant", 32'(grantId), 32'(1));
        tick(); checkOut("t4 w0", 16'h4000, 1'b0); setPort(1, 16'h4001, 1'b1, 1'b0);
        tick(); checkOut("t4 w1", 16'h4001, 1'b0); setPort(1, 16'h4002, 1'b1, 1'b0);
        dataOutStop = 1'b1;
        #1 check("t4 stall stop", 32'(reqStop), 32'(4'hF));
        for (int c = 0; c < 5; c++) begin
            tick(); checkOut("t4 hold", 16'h4001, 1'b0);
            check("t4 hold stop", 32'(reqStop), 32'(4'hF));
        end
        dataOutStop = 1'b0;
        #1 check("t4 resume stop", 32'(reqStop), 32'(4'b1101));
        for (int w = 2; w < 8; w++) begin
            tick(); checkOut("t4 word", 16'(16'h4000 + w), w == 7);
            if (w < 7) setPort(1, 16'(16'h4000 + w + 1), 1'b1, (w + 1) == 7);
            else setPort(1, 16'h0000, 1'b0, 1'b0);
        end

        // Reset in the middle of a port 3 burst
        setPort(3, 16'h5000, 1'b1, 1'b0);
        tick(); check("t5 grant", 32'(grantId), 32'(3));
        tick(); checkOut("t5 w0", 16'h5000, 1'b0); setPort(3, 16'h5001, 1'b1, 1'b0);
        tick(); checkOut("t5 w1", 16'h5001, 1'b0); setPort(3, 16'h5002, 1'b1, 1'b0);
        srst = 1'b1;
        tick(); checkReset("t5 reset");
        srst = 1'b0;
        setPort(0, 16'h5100, 1'b1, 1'b1);
        tick(); check("t5 grant after reset", 32'(grantId), 32'(0));
        tick(); checkOut("t5 p0 word", 16'h5100, 1'b1);
        reqValid = '0; reqLast = '0;
        tick();

        // MaxBurst=1 instance, ports 1 and 3 alternate
        reqData1[1*DW +: DW] = 16'h6100;
        reqData1[3*DW +: DW] = 16'h6300;
        reqValid1 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 1) ? 3 : 1;
            tick();
            check("t6 grant", 32'(grantId1), 32'(g));
            check("t6 busy", 32'(busy1), 32'(1));
            tick();
            check("t6 valid", 32'(dataOutValid1), 32'(1));
            check("t6 data", 32'(dataOut1), 32'(16'(16'h6000 + g * 256)));
            check("t6 last", 32'(dataOutLast1), 32'(1));
            check("t6 release", 32'(busy1), 32'(0));
        end
        reqValid1 = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_output_arbiter.md
# axi_output_arbiter

Round-robin arbiter that shares a single AXI output buffer between NumPorts upstream SELF-style producers. Grants one producer at a time for a whole burst (terminated by its last flag or by a MaxBurst word limit), forwards its words through a one-entry registered output stage to the output buffer's data input side, and rotates priority after each burst. Sits between kernel-side stream producers and the AXI output buffer in the host-write path.

## Interface

- DataWidth, 16, width of every data word
- NumPorts, 4, number of requesters; legal range 2..8
- MaxBurst, 16, maximum words per grant; legal range 1..256

- clk  input  1  clock; all state updates on rising edge
- srst  input  1  synchronous active-high reset
- reqValid  input  NumPorts  per-port word valid
- reqData  input  NumPorts*DataWidth  port i occupies bits [i*DataWidth +: DataWidth]
- reqLast  input  NumPorts  per-port last-word-of-burst flag, qualified by reqValid
- reqStop  output  NumPorts  per-port back-pressure; 1 = word not accepted
- dataOutValid  output  1  registered word valid toward output buffer
- dataOut  output  DataWidth  registered word
- dataOutLast  output  1  registered last flag (1 on final word of each grant, whether from reqLast or MaxBurst)
- dataOutStop  input  1  back-pressure from output buffer
- grantId  output  clog2(NumPorts)  index of current/most recent grantee
- busy  output  1  1 while in state GRANT

## Operation

- Transfer rule (both sides): word moves on a cycle where valid=1 and stop=0.
- State machine: IDLE, GRANT.
  - IDLE: if any reqValid, select first asserted port scanning upward from rrPtr with wrap (rrPtr, rrPtr+1, …, NumPorts-1, 0, …); register grantId, clear burst counter, go GRANT. No reqValid: stay IDLE.
  - GRANT: reqStop[grantId] = ~(~dataOutValid | ~dataOutStop); all other reqStop bits = 1. Accepted word loads output register (dataOut, dataOutLast, dataOutValid=1); counter increments.
  - Release: on accepted word with reqLast=1, or with counter = MaxBurst-1; dataOutLast set for that word; rrPtr <= (grantId+1) mod NumPorts; go IDLE.
- Output register: cleared (dataOutValid=0) when it transfers downstream and no new word loads that cycle; load and drain in the same cycle allowed (full throughput).
- Counter width clog2(MaxBurst)+1; never exceeds MaxBurst-1.
- Granted port dropping reqValid mid-burst: grant held indefinitely, no timeout.
- reqLast and MaxBurst limit on same word: single release, dataOutLast=1.
- MaxBurst=1: every grant is exactly one word.
- Non-granted ports: reqStop=1 always; in IDLE all reqStop=1.

## Timing

- Reset values: state IDLE, rrPtr 0, grantId 0, counter 0, dataOutValid 0, dataOut 0, dataOutLast 0, busy 0, reqStop all 1.
- Reset mid-burst: word in output register discarded, grant dropped, rrPtr returns to 0.
- Request at cycle t (IDLE) -> busy=1 and reqStop[g]=0 at t+1 -> first word accepted t+1 -> dataOutValid at t+2. Latency input-to-output 1 cycle.
- Steady-state throughput 1 word/cycle within a burst when dataOutStop=0.
- Inter-burst gap: last word accepted at k -> IDLE at k+1 -> next grant at k+2 (one bubble on input side; output may still be draining).
- dataOutStop -> reqStop path is combinational; all other outputs registered.
- Output register holds value stable while dataOutValid=1 and dataOutStop=1.

## Test plan

- Single port 0, 3-word burst (0x0011,0x0022,0x0033, last on third), dataOutStop=0 -> dataOut same sequence cycles t+2..t+4, dataOutLast only on 0x0033, busy falls at t+4, rrPtr=1.
- All four ports continuously valid with 2-word bursts -> grantId sequence 0,1,2,3,0; one IDLE cycle between grants; no word of a non-granted port accepted.
- Port 2 streams 20 words with no reqLast, MaxBurst=16 -> grant released after word 16 with dataOutLast=1, next grant port 3 if valid else port 2 again after IDLE.
- dataOutStop held 1 for 5 cycles mid-burst -> dataOut stable, reqStop[g]=1 once register full, no word lost or duplicated on release.
- srst asserted for one cycle mid-burst -> next cycle all reset values above, dataOutValid=0, following arbitration starts from port 0.
- MaxBurst=1 with ports 1 and 3 valid -> alternating single-word grants 1,3,1,3, each with dataOutLast=1.
